// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: select encodings and widths.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fwd_hazard_unit_pkg;

  // Default register index width for the NPC register file (32 entries).
  localparam int REG_ADDR_WIDTH_DEF = 5;

  // Operand select encoding: 0 takes the value read from the register file.
  localparam int FWD_SEL_REGFILE = 0;

  // Completion-bus select follows the last forwarding stage, so it
  // depends on how many stages are configured.
  function automatic int fwd_sel_cmp(input int num_stages);
    return num_stages + 1;
  endfunction

  // Width needed to encode regfile + every stage + completion bus.
  function automatic int fwd_sel_width(input int num_stages);
    return $clog2(num_stages + 2);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-source operand match: chooses the forwarding source for one EX operand.
// Latency: purely combinational, zero cycles.
// Backpressure: raises stall_o on load-use or on an outstanding long producer.
module fwd_src_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int NUM_STAGES     = 2,
  parameter int SEL_W          = fwd_sel_width(NUM_STAGES)
) (
  input  logic                               vld_i,
  input  logic [REG_ADDR_WIDTH-1:0]          rs_i,
  input  logic [NUM_STAGES*REG_ADDR_WIDTH-1:0] stg_waddr_i,
  input  logic [NUM_STAGES-1:0]              stg_wen_i,
  input  logic [NUM_STAGES-1:0]              stg_ready_i,
  input  logic                               cmp_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]          cmp_rd_i,
  input  logic [2**REG_ADDR_WIDTH-1:0]       busy_i,
  output logic [SEL_W-1:0]                   sel_o,
  output logic                               stall_o
);

  logic hit;

  // Priority search: youngest matching stage, then completion bus, then scoreboard.
  always_comb begin
    sel_o   = SEL_W'(FWD_SEL_REGFILE);
    stall_o = 1'b0;
    hit     = 1'b0;
    if (vld_i && (rs_i != '0)) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (!hit && stg_wen_i[s] &&
            (stg_waddr_i[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rs_i)) begin
          hit     = 1'b1;
          sel_o   = SEL_W'(s + 1);
          // Matching producer whose data is not yet available: load-use.
          stall_o = ~stg_ready_i[s];
        end
      end
      if (!hit) begin
        if (cmp_valid_i && (cmp_rd_i == rs_i)) begin
          sel_o = SEL_W'(fwd_sel_cmp(NUM_STAGES));
        end else if (busy_i[rs_i]) begin
          // Long producer still in flight and not on the bus this cycle.
          stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects, stall generation, long-latency scoreboard, stall stats.
// Latency: selects and stall are combinational; busy/counters update one cycle later.
// Backpressure: ex_stall holds EX and earlier stages; watchdog flags runaway stalls.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter  int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter  int NUM_SRC        = 2,
  parameter  int NUM_STAGES     = 2,
  parameter  int TIMEOUT        = 1024,
  localparam int SEL_W          = fwd_sel_width(NUM_STAGES)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ex_valid,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]    ex_rs,
  input  logic [NUM_SRC-1:0]                   ex_rs_used,
  input  logic [REG_ADDR_WIDTH-1:0]            ex_rd,
  input  logic                                 ex_rd_wen,
  input  logic                                 ex_long,
  input  logic [NUM_STAGES*REG_ADDR_WIDTH-1:0] stg_waddr,
  input  logic [NUM_STAGES-1:0]                stg_wen,
  input  logic [NUM_STAGES-1:0]                stg_ready,
  input  logic                                 cmp_valid,
  input  logic [REG_ADDR_WIDTH-1:0]            cmp_rd,
  output logic [NUM_SRC*SEL_W-1:0]             fwd_sel,
  output logic                                 ex_stall,
  output logic [2**REG_ADDR_WIDTH-1:0]         busy,
  output logic [31:0]                          stall_cycles,
  output logic                                 hazard_timeout
);

  localparam int NREG  = 2**REG_ADDR_WIDTH;
  localparam int RUN_W = $clog2(TIMEOUT + 1);

  logic [NREG-1:0]    busy_q, busy_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               timeout_q, timeout_d;
  logic [NUM_SRC-1:0] src_stall;
  logic               waw_stall;
  logic               sb_set;

  // One matcher per source operand.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_STAGES     (NUM_STAGES),
      .SEL_W          (SEL_W)
    ) u_match (
      .vld_i       (ex_valid & ex_rs_used[i]),
      .rs_i        (ex_rs[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .stg_waddr_i (stg_waddr),
      .stg_wen_i   (stg_wen),
      .stg_ready_i (stg_ready),
      .cmp_valid_i (cmp_valid),
      .cmp_rd_i    (cmp_rd),
      .busy_i      (busy_q),
      .sel_o       (fwd_sel[i*SEL_W +: SEL_W]),
      .stall_o     (src_stall[i])
    );
  end

  // WAW: a new write to a register a long producer still owns must wait,
  // unless that producer completes this very cycle.
  always_comb begin
    waw_stall = 1'b0;
    if (ex_valid && ex_rd_wen && (ex_rd != '0) && busy_q[ex_rd] &&
        !(cmp_valid && (cmp_rd == ex_rd))) begin
      waw_stall = 1'b1;
    end
  end

  assign ex_stall = (|src_stall) | waw_stall;
  assign sb_set   = ex_valid & ex_long & ex_rd_wen & (ex_rd != '0) & ~ex_stall;

  // Scoreboard next state: completion clears, issue sets (set applied last so it wins).
  always_comb begin
    busy_d = busy_q;
    if (cmp_valid) begin
      busy_d[cmp_rd] = 1'b0;
    end
    if (sb_set) begin
      busy_d[ex_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Stall statistics: saturating total and a consecutive-run watchdog.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    run_d       = run_q;
    if (ex_stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (run_q != RUN_W'(TIMEOUT)) begin
        run_d = run_q + RUN_W'(1);
      end
    end else begin
      run_d = '0;
    end
    timeout_d = timeout_q | (run_d == RUN_W'(TIMEOUT));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
      run_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      run_q       <= run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy           = busy_q;
  assign stall_cycles   = stall_cnt_q;
  assign hazard_timeout = timeout_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: vector table for the combinational
// select/stall logic plus sequences for scoreboard, WAW, watchdog and reset.
module tb_fwd_hazard_unit;

  localparam int W   = 5;
  localparam int TO  = 1024;
  localparam int SW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic [2*W-1:0] ex_rs;
  logic [1:0]    ex_rs_used;
  logic [W-1:0]  ex_rd;
  logic          ex_rd_wen;
  logic          ex_long;
  logic [2*W-1:0] stg_waddr;
  logic [1:0]    stg_wen;
  logic [1:0]    stg_ready;
  logic          cmp_valid;
  logic [W-1:0]  cmp_rd;
  logic [2*SW-1:0] fwd_sel;
  logic          ex_stall;
  logic [31:0]   busy;
  logic [31:0]   stall_cycles;
  logic          hazard_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_ADDR_WIDTH (W),
    .NUM_SRC        (2),
    .NUM_STAGES     (2),
    .TIMEOUT        (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_rs          (ex_rs),
    .ex_rs_used     (ex_rs_used),
    .ex_rd          (ex_rd),
    .ex_rd_wen      (ex_rd_wen),
    .ex_long        (ex_long),
    .stg_waddr      (stg_waddr),
    .stg_wen        (stg_wen),
    .stg_ready      (stg_ready),
    .cmp_valid      (cmp_valid),
    .cmp_rd         (cmp_rd),
    .fwd_sel        (fwd_sel),
    .ex_stall       (ex_stall),
    .busy           (busy),
    .stall_cycles   (stall_cycles),
    .hazard_timeout (hazard_timeout)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] rs1, rs2;
    logic [1:0]   used;
    logic [W-1:0] w0, w1;
    logic [1:0]   wen, rdy;
    logic         cv;
    logic [W-1:0] crd;
    logic [SW-1:0] s1, s2;
    logic         st;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ex_valid   = 1'b0;
    ex_rs      = '0;
    ex_rs_used = '0;
    ex_rd      = '0;
    ex_rd_wen  = 1'b0;
    ex_long    = 1'b0;
    stg_waddr  = '0;
    stg_wen    = '0;
    stg_ready  = '0;
    cmp_valid  = 1'b0;
    cmp_rd     = '0;
  endtask

  task automatic issue_long(input logic [W-1:0] rd);
    idle();
    ex_valid  = 1'b1;
    ex_long   = 1'b1;
    ex_rd     = rd;
    ex_rd_wen = 1'b1;
  endtask

  task automatic consume_rs1(input logic [W-1:0] rs);
    idle();
    ex_valid   = 1'b1;
    ex_rs      = {5'd0, rs};
    ex_rs_used = 2'b01;
  endtask

  initial begin
    // v rs1 rs2 used w0 w1 wen rdy cv crd | sel1 sel2 stall
    vecs[0]  = '{1'b0, 5'd5,  5'd0,  2'b01, 5'd5,  5'd0,  2'b01, 2'b11, 1'b0, 5'd0,  2'd0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 5'd5,  5'd0,  2'b01, 5'd5,  5'd5,  2'b11, 2'b11, 1'b0, 5'd0,  2'd1, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 5'd5,  5'd0,  2'b01, 5'd6,  5'd5,  2'b11, 2'b11, 1'b0, 5'd0,  2'd2, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  5'd7,  2'b10, 5'd7,  5'd0,  2'b01, 2'b00, 1'b0, 5'd0,  2'd0, 2'd1, 1'b1};
    vecs[4]  = '{1'b1, 5'd3,  5'd0,  2'b01, 5'd0,  5'd3,  2'b10, 2'b01, 1'b0, 5'd0,  2'd2, 2'd0, 1'b1};
    vecs[5]  = '{1'b1, 5'd5,  5'd0,  2'b01, 5'd5,  5'd0,  2'b00, 2'b11, 1'b0, 5'd0,  2'd0, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 5'd0,  5'd12, 2'b10, 5'd0,  5'd0,  2'b00, 2'b00, 1'b1, 5'd12, 2'd0, 2'd3, 1'b0};
    vecs[7]  = '{1'b1, 5'd12, 5'd0,  2'b01, 5'd0,  5'd12, 2'b10, 2'b10, 1'b1, 5'd12, 2'd2, 2'd0, 1'b0};
    vecs[8]  = '{1'b1, 5'd0,  5'd7,  2'b00, 5'd7,  5'd0,  2'b01, 2'b00, 1'b0, 5'd0,  2'd0, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 5'd0,  5'd0,  2'b11, 5'd0,  5'd0,  2'b11, 2'b00, 1'b1, 5'd0,  2'd0, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 5'd8,  5'd9,  2'b11, 5'd9,  5'd8,  2'b11, 2'b11, 1'b0, 5'd0,  2'd2, 2'd1, 1'b0};
    vecs[11] = '{1'b1, 5'd11, 5'd0,  2'b01, 5'd11, 5'd11, 2'b11, 2'b01, 1'b0, 5'd0,  2'd1, 2'd0, 1'b0};

    // Reset state.
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_stall_cycles", stall_cycles, 0);
    chk("reset_timeout", hazard_timeout, 0);
    chk("reset_ex_stall", ex_stall, 0);
    rst_n = 1'b1;

    // Combinational vector table; busy is all zero throughout.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle();
      ex_valid   = vecs[i].v;
      ex_rs      = {vecs[i].rs2, vecs[i].rs1};
      ex_rs_used = vecs[i].used;
      stg_waddr  = {vecs[i].w1, vecs[i].w0};
      stg_wen    = vecs[i].wen;
      stg_ready  = vecs[i].rdy;
      cmp_valid  = vecs[i].cv;
      cmp_rd     = vecs[i].crd;
      #1;
      chk($sformatf("vec%0d_sel1", i), fwd_sel[SW-1:0], vecs[i].s1);
      chk($sformatf("vec%0d_sel2", i), fwd_sel[2*SW-1:SW], vecs[i].s2);
      chk($sformatf("vec%0d_stall", i), ex_stall, vecs[i].st);
    end
    @(negedge clk);
    idle();
    chk("table_stall_cycles", stall_cycles, 2);

    // Fresh start for the sequences.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: stalls while in EXE/MEM, forwards from stage 1 next cycle.
    idle();
    ex_valid = 1'b1; ex_rs = {5'd7, 5'd0}; ex_rs_used = 2'b10;
    stg_waddr = {5'd0, 5'd7}; stg_wen = 2'b01; stg_ready = 2'b00;
    #1;
    chk("lu_stall", ex_stall, 1);
    chk("lu_sel2", fwd_sel[2*SW-1:SW], 1);
    @(negedge clk);
    stg_waddr = {5'd7, 5'd0}; stg_wen = 2'b10; stg_ready = 2'b10;
    #1;
    chk("lu2_stall", ex_stall, 0);
    chk("lu2_sel2", fwd_sel[2*SW-1:SW], 2);
    chk("lu_stall_cycles", stall_cycles, 1);

    // Scoreboard: long producer to r9, consumer stalls, completion forwards.
    @(negedge clk);
    issue_long(5'd9);
    #1;
    chk("sb_issue_stall", ex_stall, 0);
    chk("sb_busy_not_yet", busy[9], 0);
    @(negedge clk);
    chk("sb_busy_set", busy, 32'h0000_0200);
    consume_rs1(5'd9);
    #1;
    chk("sb_cons_stall", ex_stall, 1);
    chk("sb_cons_sel", fwd_sel[SW-1:0], 0);
    @(negedge clk);
    cmp_valid = 1'b1; cmp_rd = 5'd9;
    #1;
    chk("sb_cmp_sel", fwd_sel[SW-1:0], 3);
    chk("sb_cmp_stall", ex_stall, 0);
    @(negedge clk);
    chk("sb_busy_clr", busy, 0);
    cmp_valid = 1'b0;
    #1;
    chk("sb_after_sel", fwd_sel[SW-1:0], 0);
    chk("sb_after_stall", ex_stall, 0);

    // WAW on a busy destination.
    @(negedge clk);
    issue_long(5'd4);
    @(negedge clk);
    chk("waw_busy", busy, 32'h0000_0010);
    idle();
    ex_valid = 1'b1; ex_rd = 5'd4; ex_rd_wen = 1'b1;
    #1;
    chk("waw_stall", ex_stall, 1);
    @(negedge clk);
    cmp_valid = 1'b1; cmp_rd = 5'd4;
    #1;
    chk("waw_cmp_nostall", ex_stall, 0);
    @(negedge clk);
    chk("waw_busy_clr", busy, 0);

    // Zero register: never forwards, never stalls, never busy.
    idle();
    ex_valid = 1'b1; ex_long = 1'b1; ex_rd_wen = 1'b1; ex_rd = 5'd0;
    ex_rs_used = 2'b11; stg_wen = 2'b11; stg_ready = 2'b00;
    #1;
    chk("zero_stall", ex_stall, 0);
    chk("zero_sel", fwd_sel, 0);
    @(negedge clk);
    chk("zero_busy", busy, 0);
    chk("seq_stall_cycles", stall_cycles, 3);

    // Watchdog: exactly TIMEOUT consecutive stalled cycles.
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue_long(5'd3);
    @(negedge clk);
    consume_rs1(5'd3);
    repeat (TO - 1) @(negedge clk);
    chk("wd_not_yet", hazard_timeout, 0);
    chk("wd_cnt_m1", stall_cycles, TO - 1);
    @(negedge clk);
    chk("wd_fired", hazard_timeout, 1);
    chk("wd_cnt", stall_cycles, TO);
    chk("wd_busy3", busy, 32'h0000_0008);

    // Reset in the middle of the stall with busy[3] and the flag set.
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", stall_cycles, 0);
    chk("rst_timeout", hazard_timeout, 0);
    rst_n = 1'b1;
    idle();
    cmp_valid = 1'b1; cmp_rd = 5'd3;
    @(negedge clk);
    chk("rst_late_cmp_busy", busy, 0);

    // One non-stall cycle just before TIMEOUT restarts the run.
    issue_long(5'd3);
    @(negedge clk);
    consume_rs1(5'd3);
    repeat (TO - 1) @(negedge clk);
    idle();
    @(negedge clk);
    chk("wd_gap_flag", hazard_timeout, 0);
    chk("wd_gap_cnt", stall_cycles, TO - 1);
    consume_rs1(5'd3);
    repeat (TO - 1) @(negedge clk);
    chk("wd_restart_flag", hazard_timeout, 0);
    chk("wd_restart_cnt", stall_cycles, 2 * (TO - 1));
    @(negedge clk);
    chk("wd_restart_fired", hazard_timeout, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
